// File: rtl/anton_neopixel_rx_pkg.sv
// ============================================================================
// anton_neopixel_rx_pkg
// Types and helpers shared by the NeoPixel receiver.
//   rxState_t  - receiver FSM state encoding
//   satInc13   - saturating increment for the 13-bit byte counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package anton_neopixel_rx_pkg;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } rxState_t;

    localparam int BYTE_COUNT_W = 13;

    function automatic logic [BYTE_COUNT_W-1:0] satInc13(input logic [BYTE_COUNT_W-1:0] value);
        return (value == {BYTE_COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/anton_common.vh
// ============================================================================
// anton_common.vh
// Shared default values for the anton block family.
// Provides:
//   BUFFER_END, RESET_DELAY                  - buffer / reset sequencing defaults
//   ANTON_NEOPIXEL_HIGH_THRESHOLD            - min high ticks for a '1' bit
//   ANTON_NEOPIXEL_MAX_HIGH                  - high ticks that flag an error
//   ANTON_NEOPIXEL_RESET_DETECT              - low ticks that end a frame
// Revision: 1.0 - initial release
// ============================================================================
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH

`define BUFFER_END                      1023
`define RESET_DELAY                     16

// NeoPixel receiver timing, in ticks of the 6.4 MHz sample clock
`define ANTON_NEOPIXEL_HIGH_THRESHOLD   4
`define ANTON_NEOPIXEL_MAX_HIGH         8
`define ANTON_NEOPIXEL_RESET_DETECT     320

`endif

// File: rtl/anton_neopixel_rx_sync.sv
// ============================================================================
// anton_neopixel_rx_sync
// Two-flop synchronizer bringing the asynchronous NeoPixel line into the
// sample clock domain.
// Ports:
//   clk6_4mhz  in   sample clock
//   reset      in   asynchronous active-high reset
//   asyncIn    in   raw asynchronous line
//   syncOut    out  synchronized line (second flop)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module anton_neopixel_rx_sync (
    input  logic clk6_4mhz,
    input  logic reset,
    input  logic asyncIn,
    output logic syncOut
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= asyncIn;
            r_sync <= r_meta;
        end
    end

    assign syncOut = r_sync;

endmodule

`default_nettype wire

// File: rtl/anton_neopixel_rx.sv
// ============================================================================
// anton_neopixel_rx
// NeoPixel (WS2812-style) serial receiver. Decodes bits from high-pulse width,
// assembles MSB-first bytes, and detects the low reset gap that ends a frame.
// Ports:
//   clk6_4mhz  in   sample clock (6.4 MHz), rising edge
//   reset      in   asynchronous active-high reset
//   neoData    in   serial line, asynchronous
//   rxData     out  [7:0]  last completed byte
//   rxValid    out  one-cycle strobe, rxData updated
//   frameEnd   out  one-cycle strobe, reset gap seen after activity
//   rxError    out  one-cycle strobe, over-long high or partial byte at end
//   byteCount  out  [12:0] bytes in current/last frame, saturating
//   busy       out  high while inside a frame (HIGH/LOW states)
// Revision: 1.0 - initial release
// ============================================================================
`include "anton_common.vh"
`default_nettype none

module anton_neopixel_rx
    import anton_neopixel_rx_pkg::*;
#(
    parameter int HIGH_THRESHOLD = `ANTON_NEOPIXEL_HIGH_THRESHOLD,
    parameter int MAX_HIGH       = `ANTON_NEOPIXEL_MAX_HIGH,
    parameter int RESET_DETECT   = `ANTON_NEOPIXEL_RESET_DETECT
) (
    input  logic        clk6_4mhz,
    input  logic        reset,
    input  logic        neoData,
    output logic [7:0]  rxData,
    output logic        rxValid,
    output logic        frameEnd,
    output logic        rxError,
    output logic [12:0] byteCount,
    output logic        busy
);

    localparam int HIGH_W = $clog2(MAX_HIGH + 1);
    localparam int LOW_W  = $clog2(RESET_DETECT + 1);

    localparam logic [HIGH_W-1:0] c_highThreshold = HIGH_W'(HIGH_THRESHOLD);
    // Compare against limit-1: the sample that pushes the count to the limit
    // is the one that triggers the action.
    localparam logic [HIGH_W-1:0] c_maxHighM1     = HIGH_W'(MAX_HIGH - 1);
    localparam logic [LOW_W-1:0]  c_lowLimitM1    = LOW_W'(RESET_DETECT - 1);

    logic              neoSync;
    logic              r_neoPrev;
    rxState_t          r_state;
    logic [HIGH_W-1:0] r_highCount;
    logic [LOW_W-1:0]  r_lowCount;
    logic [2:0]        r_bitIndex;
    logic [6:0]        r_shift;

    logic              w_rise;
    logic              w_fall;
    logic              w_bit;
    logic [7:0]        w_shiftNext;

    anton_neopixel_rx_sync u_sync (
        .clk6_4mhz (clk6_4mhz),
        .reset     (reset),
        .asyncIn   (neoData),
        .syncOut   (neoSync)
    );

    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            r_neoPrev <= 1'b0;
        end else begin
            r_neoPrev <= neoSync;
        end
    end

    assign w_rise      = neoSync & ~r_neoPrev;
    assign w_fall      = ~neoSync & r_neoPrev;
    assign w_bit       = (r_highCount >= c_highThreshold);
    assign w_shiftNext = {r_shift, w_bit};

    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            r_state     <= WAIT_GAP;
            r_highCount <= '0;
            r_lowCount  <= '0;
            r_bitIndex  <= '0;
            r_shift     <= '0;
            rxData      <= '0;
            rxValid     <= 1'b0;
            frameEnd    <= 1'b0;
            rxError     <= 1'b0;
            byteCount   <= '0;
            busy        <= 1'b0;
        end else begin
            rxValid  <= 1'b0;
            frameEnd <= 1'b0;
            rxError  <= 1'b0;

            case (r_state)
                // Wait for a clean low gap before trusting the line again.
                WAIT_GAP: begin
                    if (neoSync) begin
                        r_lowCount <= '0;
                    end else if (r_lowCount == c_lowLimitM1) begin
                        r_lowCount <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_lowCount <= r_lowCount + 1'b1;
                    end
                end

                IDLE: begin
                    if (w_rise) begin
                        r_state     <= HIGH;
                        r_highCount <= HIGH_W'(1);
                        byteCount   <= '0;
                        r_bitIndex  <= '0;
                        r_shift     <= '0;
                        busy        <= 1'b1;
                    end
                end

                HIGH: begin
                    if (w_fall) begin
                        r_shift    <= w_shiftNext[6:0];
                        r_lowCount <= LOW_W'(1);
                        r_state    <= LOW;
                        if (r_bitIndex == 3'd7) begin
                            rxData     <= w_shiftNext;
                            rxValid    <= 1'b1;
                            byteCount  <= satInc13(byteCount);
                            r_bitIndex <= '0;
                        end else begin
                            r_bitIndex <= r_bitIndex + 1'b1;
                        end
                    end else if (r_highCount == c_maxHighM1) begin
                        // Line stuck high: abandon the frame and resync on a gap.
                        rxError     <= 1'b1;
                        r_state     <= WAIT_GAP;
                        r_lowCount  <= '0;
                        r_highCount <= '0;
                        r_bitIndex  <= '0;
                        r_shift     <= '0;
                        busy        <= 1'b0;
                    end else begin
                        r_highCount <= r_highCount + 1'b1;
                    end
                end

                LOW: begin
                    if (w_rise) begin
                        r_state     <= HIGH;
                        r_highCount <= HIGH_W'(1);
                    end else if (r_lowCount == c_lowLimitM1) begin
                        frameEnd   <= 1'b1;
                        rxError    <= (r_bitIndex != 3'd0);
                        r_bitIndex <= '0;
                        r_shift    <= '0;
                        r_lowCount <= '0;
                        r_state    <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        r_lowCount <= r_lowCount + 1'b1;
                    end
                end

                default: begin
                    r_state <= WAIT_GAP;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_rx.sv
// ============================================================================
// tb_anton_neopixel_rx
// Directed self-checking bench for anton_neopixel_rx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anton_neopixel_rx;

    logic        clk6_4mhz = 1'b0;
    logic        reset;
    logic        neoData;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        frameEnd;
    logic        rxError;
    logic [12:0] byteCount;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         validCount;
    int         frameCount;
    int         errCount;
    int         bothCount;
    int         validCyc;
    int         fallCyc;
    logic [7:0] lastData;
    logic [7:0] rxQ[$];

    anton_neopixel_rx dut (
        .clk6_4mhz (clk6_4mhz),
        .reset     (reset),
        .neoData   (neoData),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .frameEnd  (frameEnd),
        .rxError   (rxError),
        .byteCount (byteCount),
        .busy      (busy)
    );

    always #5 clk6_4mhz = ~clk6_4mhz;

    always @(posedge clk6_4mhz) cyc <= cyc + 1;

    // Strobe monitor, sampled just after each active edge
    always @(posedge clk6_4mhz) begin
        #1;
        if (rxValid === 1'b1) begin
            validCount++;
            lastData = rxData;
            rxQ.push_back(rxData);
            validCyc = cyc;
        end
        if (frameEnd === 1'b1) frameCount++;
        if (rxError === 1'b1) errCount++;
        if (frameEnd === 1'b1 && rxError === 1'b1) bothCount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk6_4mhz);
    endtask

    task automatic pulse(input int h, input int l);
        neoData = 1'b1;
        ticks(h);
        neoData = 1'b0;
        fallCyc = cyc;
        ticks(l);
    endtask

    task automatic sendBit(input logic b);
        if (b) pulse(6, 2);
        else   pulse(2, 6);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic gap(input int n);
        neoData = 1'b0;
        ticks(n);
    endtask

    task automatic clearMon;
        validCount = 0;
        frameCount = 0;
        errCount   = 0;
        bothCount  = 0;
        validCyc   = 0;
        lastData   = 8'h00;
        rxQ.delete();
    endtask

    initial begin
        reset   = 1'b1;
        neoData = 1'b0;
        fallCyc = 0;
        clearMon();
        ticks(3);

        // Reset state
        check("rst_rxData",    32'(rxData),    32'h0);
        check("rst_rxValid",   32'(rxValid),   32'h0);
        check("rst_frameEnd",  32'(frameEnd),  32'h0);
        check("rst_rxError",   32'(rxError),   32'h0);
        check("rst_byteCount", 32'(byteCount), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);

        reset = 1'b0;
        gap(330);

        // Single byte 0xA5
        clearMon();
        sendByte(8'hA5);
        gap(340);
        check("a5_validCount", 32'(validCount), 32'd1);
        check("a5_data",       32'(lastData),   32'hA5);
        check("a5_latency",    32'(validCyc - fallCyc), 32'd3);
        check("a5_frameEnd",   32'(frameCount), 32'd1);
        check("a5_noError",    32'(errCount),   32'd0);
        check("a5_byteCount",  32'(byteCount),  32'd1);
        check("a5_idleBusy",   32'(busy),       32'h0);

        // Back-to-back bytes
        clearMon();
        sendByte(8'hFF);
        sendByte(8'h00);
        sendByte(8'h81);
        gap(340);
        check("b2b_validCount", 32'(validCount), 32'd3);
        check("b2b_byte0",      32'(rxQ.size() > 0 ? rxQ[0] : 8'hEE), 32'hFF);
        check("b2b_byte1",      32'(rxQ.size() > 1 ? rxQ[1] : 8'hEE), 32'h00);
        check("b2b_byte2",      32'(rxQ.size() > 2 ? rxQ[2] : 8'hEE), 32'h81);
        check("b2b_frameEnd",   32'(frameCount), 32'd1);
        check("b2b_byteCount",  32'(byteCount),  32'd3);
        check("b2b_rxData",     32'(rxData),     32'h81);

        // Threshold boundary: high 3 -> 0, high 4 -> 1
        clearMon();
        for (int i = 0; i < 6; i++) pulse(2, 6);
        pulse(3, 5);
        pulse(4, 4);
        gap(340);
        check("thr_validCount", 32'(validCount), 32'd1);
        check("thr_data",       32'(lastData),   32'h01);
        check("thr_noError",    32'(errCount),   32'd0);

        // Over-long high pulse mid-byte
        clearMon();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        pulse(10, 4);
        sendByte(8'hFF);
        check("long_error",     32'(errCount),   32'd1);
        check("long_noValid",   32'(validCount), 32'd0);
        check("long_noFrame",   32'(frameCount), 32'd0);
        check("long_notBusy",   32'(busy),       32'h0);
        gap(340);
        sendByte(8'h3C);
        gap(340);
        check("long_recValid",  32'(validCount), 32'd1);
        check("long_recData",   32'(lastData),   32'h3C);
        check("long_errOnce",   32'(errCount),   32'd1);

        // Partial byte at frame end
        clearMon();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        gap(340);
        check("part_frameEnd",  32'(frameCount), 32'd1);
        check("part_error",     32'(errCount),   32'd1);
        check("part_sameCycle", 32'(bothCount),  32'd1);
        check("part_noValid",   32'(validCount), 32'd0);
        check("part_byteCount", 32'(byteCount),  32'd0);
        check("part_rxDataHeld", 32'(rxData),    32'h3C);

        // Reset after four bits of 0xC3
        clearMon();
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        check("mid_busy",       32'(busy),       32'h1);
        reset = 1'b1;
        ticks(2);
        check("mid_rxData",     32'(rxData),     32'h0);
        check("mid_busyOff",    32'(busy),       32'h0);
        check("mid_byteCount",  32'(byteCount),  32'h0);
        check("mid_strobes",    32'({rxValid, frameEnd, rxError}), 32'h0);
        reset = 1'b0;
        ticks(10);
        sendByte(8'h5A);
        gap(20);
        check("mid_ignored",    32'(validCount), 32'd0);
        gap(340);
        sendByte(8'h5A);
        gap(340);
        check("mid_recValid",   32'(validCount), 32'd1);
        check("mid_recData",    32'(lastData),   32'h5A);
        check("mid_recCount",   32'(byteCount),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/anton_neopixel_rx.md
ANTON_NEOPIXEL_RX -- requirements
Module: anton_neopixel_rx

Interface
REQ-001 SHALL have parameter HIGH_THRESHOLD, default 4: a high pulse of at least this many clk6_4mhz ticks decodes as bit 1; shorter decodes as bit 0.
REQ-002 SHALL have parameter MAX_HIGH, default 8: a high pulse reaching this many ticks is a protocol error.
REQ-003 SHALL have parameter RESET_DETECT, default 320 (50us at 6.4MHz): low time in ticks that ends a frame.
REQ-004 clk6_4mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 neoData  input  1  serial NeoPixel line; asynchronous to clk6_4mhz.
REQ-007 rxData  output  8  last completed byte, MSB received first.
REQ-008 rxValid  output  1  one-cycle strobe; rxData is new this cycle.
REQ-009 frameEnd  output  1  one-cycle strobe on reset-gap detection after at least one rising edge.
REQ-010 rxError  output  1  one-cycle strobe on over-long high pulse or partial byte at frame end.
REQ-011 byteCount  output  13  bytes received in current or last frame, saturating at 8191.
REQ-012 busy  output  1  high in states HIGH and LOW.

Function
REQ-013 neoData SHALL pass through a 2-flop synchronizer (neoSync); all decoding uses neoSync and its one-cycle-delayed copy.
REQ-014 FSM states SHALL be WAIT_GAP, IDLE, HIGH, LOW.
- WAIT_GAP: count consecutive low ticks, clear the count on a high sample; on reaching RESET_DETECT go to IDLE. No decoding, no strobes.
- IDLE: on a rising edge go to HIGH, highCount=1, clear byteCount, bitIndex and shift register.
- HIGH: increment highCount each tick while high; on a falling edge, shift in (highCount>=HIGH_THRESHOLD), bitIndex+1, go to LOW, lowCount=1.
- HIGH: if highCount reaches MAX_HIGH while still high, pulse rxError, discard the partial byte, go to WAIT_GAP.
- LOW: on a rising edge go to HIGH, highCount=1; on lowCount reaching RESET_DETECT pulse frameEnd and go to IDLE.
REQ-015 On the 8th bit of a byte, the block SHALL load rxData, pulse rxValid, increment byteCount (saturating) and clear bitIndex, all in the cycle after the falling edge is seen on neoSync.
REQ-016 Latency from a neoData falling edge to rxValid SHALL be 3 clk6_4mhz cycles (2 sync + 1 register).
REQ-017 If bitIndex is non-zero at frame end, the block SHALL pulse rxError in the same cycle as frameEnd and discard the partial byte; rxValid SHALL NOT assert.
REQ-018 Bit timing SHALL be derived from pulse widths only; low-phase length below RESET_DETECT SHALL NOT affect decoding.
REQ-019 Counters SHALL saturate and never wrap; widths SHALL use $clog2 of their parameter+1.
REQ-020 rxData and byteCount SHALL hold their values between strobes; byteCount SHALL hold after frameEnd until the next frame's first rising edge.

Reset
REQ-021 During reset: state=WAIT_GAP; rxData=0, rxValid=0, frameEnd=0, rxError=0, byteCount=0, busy=0; synchronizer flops=0; all counters=0.
REQ-022 Reset asserted mid-byte SHALL discard all partial state; after release, decoding SHALL resume only after a full RESET_DETECT gap.

Structure
REQ-023 Default values for HIGH_THRESHOLD, MAX_HIGH and RESET_DETECT SHALL be defines in anton_common.vh, next to the existing BUFFER_END/RESET_DELAY defaults.
REQ-024 The synchronizer SHALL be one sub-module, anton_neopixel_rx_sync (2 flops, async active-high reset); the FSM and counters stay in anton_neopixel_rx.

Verification
REQ-025 Reset, 320 low ticks, then byte 0xA5 as 8-tick bit periods (high 6 = 1, high 2 = 0), then 320 low -> one rxValid with rxData=0xA5, then frameEnd, byteCount=1, rxError never set.
REQ-026 Bytes 0xFF, 0x00, 0x81 back-to-back, then gap -> three rxValid strobes in order, frameEnd once, byteCount=3.
REQ-027 Threshold boundary: high 3 ticks then high 4 ticks (within an otherwise-0 byte) -> decoded bits 0 then 1, i.e. rxData=0x01 when placed in the last two bits.
REQ-028 High held for 8 ticks mid-byte -> rxError strobe, no rxValid, and following pulses ignored until a 320-tick low gap.
REQ-029 5 bits then 320 low -> frameEnd and rxError in the same cycle, no rxValid.
REQ-030 Reset asserted after 4 bits of 0xC3 -> all outputs 0; the next byte is decoded only after a fresh 320-tick gap.
